sha256_w_stream: RTL and testbench
==================================

// Module: sha256_w_stream
// PURPOSE
//  Streaming SHA-256 message-schedule generator for the hashing core.
//  - Loads one 512-bit padded block; emits W[0..ROUNDS-1] one word per accepted beat.
//  - Uses a 16-word sliding window with valid/ready backpressure.
//  - Replaces the single-cycle 64-word array with 16 registers plus one s0/s1 datapath.
//  - Feeds the round/compression engine, which consumes W[t] in round order.
// PARAMETERS
//  ROUNDS   64  words emitted per block, legal range 16..64.
//  IDX_W    6   width of out_idx; must satisfy 2**IDX_W >= ROUNDS.
// PORTS
//  clk            in   1    single clock, rising edge.
//  rst            in   1    asynchronous active-high reset.
//  in_valid       in   1    block_in is valid.
//  in_ready       out  1    block accepted when in_valid && in_ready.
//  block_in       in   512  padded block; W[0]=block_in[511:480], ..., W[15]=block_in[31:0].
//  abort          in   1    synchronous flush of the current block.
//  out_valid      out  1    out_w is valid.
//  out_ready      in   1    consumer accepts the word when out_valid && out_ready.
//  out_w          out  32   W[t].
//  out_idx        out  IDX_W  t, the round index of out_w.
//  out_last       out  1    high with the word whose t == ROUNDS-1.
// BEHAVIOUR
//  Reset values
//  - All outputs are 0, except in_ready=1; state=IDLE.
//  - Window and counter are cleared on reset assertion. No clock is needed.
//  State machine (2 states)
//  - IDLE: in_ready=1, out_valid=0.
//    - On in_valid: window[i] <= W[i] for i=0..15, t <= 0, go to STREAM.
//  - STREAM: in_ready=0, out_valid=1.
//    - Outputs are registered. out_w=window[0], out_idx=t, out_last=(t==ROUNDS-1).
//  Transitions on an accepted beat (out_valid && out_ready)
//  - If t < ROUNDS-1:
//    - window[i] <= window[i+1] for i=0..14.
//    - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0].
//    - t <= t+1.
//  - If t == ROUNDS-1: go to IDLE. The window is left as is and is don't-care.
//  Backpressure
//  - With out_ready=0, out_w, out_idx and out_last hold stable.
//  - The window does not shift.
//  Schedule functions
//  - s0(x) = ror(x,7) ^ ror(x,18) ^ (x>>3).
//  - s1(x) = ror(x,17) ^ ror(x,19) ^ (x>>10).
//  - All adds are modulo 2^32. Carries are discarded.
//  Latency and throughput
//  - W[0] is presented the cycle after load.
//  - Throughput is one word per cycle with out_ready held high.
//  - A block occupies ROUNDS+1 cycles including the load cycle.
//  - in_ready rises the cycle after the last accept. There is no same-cycle reload.
//  abort
//  - In STREAM: go to IDLE next cycle, out_valid=0, t=0.
//  - abort has priority over a simultaneous accept. The word is still counted as
//    consumed by the sink, but no further words are produced.
//  - In IDLE: abort has priority over in_valid; the load is dropped and in_ready stays 1.
//  Reset mid-stream
//  - Immediately returns to IDLE.
//  - out_valid falls asynchronously. No partial word is emitted afterwards.
//  ROUNDS = 16
//  - No expansion arithmetic is exercised. Words 0..15 pass through in order.
//  - out_last is asserted on t=15.
// TESTING
//  1. Load the "abc" block (0x61626380, 14 zero words, 0x00000018), out_ready=1.
//     -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
//     -> out_last on idx 63, exactly 64 beats.
//  2. Same block with out_ready toggled in a pseudo-random pattern (~50%).
//     -> Identical word/idx sequence to test 1; outputs stable while stalled.
//  3. All-ones block.
//     -> Every W[t] matches the reference model (32-bit wraparound).
//     -> W16 = s1(FFFFFFFF)+FFFFFFFF+s0(FFFFFFFF)+FFFFFFFF mod 2^32.
//  4. abort asserted during the idx=20 accept.
//     -> out_valid=0 next cycle; in_ready=1.
//     -> A new block then streams from idx 0 correctly.
//  5. rst pulsed at idx=30 between clock edges.
//     -> out_valid=0 and in_ready=1 immediately.
//     -> The next load restarts at idx 0.
//  6. ROUNDS=16 build, back-to-back blocks with in_valid held high.
//     -> 16 pass-through words per block.
//     -> One idle cycle (in_ready=1) between blocks.

Source files
------------

// File: rtl/sha256_w_stream.sv
// sha256_w_stream: streaming SHA-256 message-schedule generator.
// Loads one 512-bit padded block and emits W[0..ROUNDS-1], one word per
// accepted beat, from a 16-word sliding window with a single s0/s1 datapath.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   block load handshake (in_ready high only in IDLE)
//   block_in[511:0]      padded block, W[0] in bits 511:480
//   abort                synchronous flush of the current block
//   out_valid, out_ready word output handshake
//   out_w[31:0]          W[t]
//   out_idx[IDX_W-1:0]   t
//   out_last             high with the word t == ROUNDS-1
module sha256_w_stream #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     block_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_w,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIN_N  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   window     [WIN_N];
  logic [WORD_W-1:0]   window_nxt [WIN_N];
  logic [IDX_W-1:0]    t, t_nxt;
  logic                last_nxt;
  logic [WORD_W-1:0]   w_new;

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next schedule word W[t+16] from the current window W[t..t+15].
  assign w_new = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

  // Window head and counter are already registers; expose them directly.
  assign out_w   = window[0];
  assign out_idx = t;

  // Next-state, window and output control.
  always_comb begin
    state_nxt  = state;
    t_nxt      = t;
    last_nxt   = out_last;
    window_nxt = window;
    case (state)
      IDLE: begin
        // abort wins over a load request; the block is dropped.
        if (!abort && in_valid) begin
          for (int i = 0; i < WIN_N; i++) begin
            window_nxt[i] = block_in[WORD_W*(WIN_N-1-i) +: WORD_W];
          end
          t_nxt     = '0;
          last_nxt  = 1'b0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          // The word accepted alongside abort is consumed; nothing follows.
          state_nxt = IDLE;
          t_nxt     = '0;
          last_nxt  = 1'b0;
        end else if (out_ready) begin
          if (t == LAST_IDX) begin
            state_nxt = IDLE;
            last_nxt  = 1'b0;
          end else begin
            for (int i = 0; i < WIN_N - 1; i++) begin
              window_nxt[i] = window[i+1];
            end
            window_nxt[WIN_N-1] = w_new;
            t_nxt    = t + IDX_W'(1);
            last_nxt = ((t + IDX_W'(1)) == LAST_IDX);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, window and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      for (int i = 0; i < WIN_N; i++) begin
        window[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      out_last  <= last_nxt;
      out_valid <= (state_nxt == STREAM);
      in_ready  <= (state_nxt == IDLE);
      window    <= window_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_w_stream.sv
// Bench for sha256_w_stream: scoreboard of expected words filled at load,
// monitors pop and compare on every accepted output beat.
module tb_sha256_w_stream;

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] block_in = '0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_w;
  logic [5:0]   out_idx;
  logic         out_last;

  logic         in_valid16 = 1'b0;
  logic         in_ready16;
  logic [511:0] block_in16 = '0;
  logic         out_valid16;
  logic         out_ready16 = 1'b1;
  logic [31:0]  out_w16;
  logic [3:0]   out_idx16;
  logic         out_last16;

  exp_t        sb[$];
  exp_t        sb16[$];
  logic [31:0] ref_w [64];
  logic [31:0] got_w [64];
  int          n_checks = 0;
  int          n_fail = 0;
  int          beats64 = 0;
  int          beats16 = 0;
  int          ready_ctl = 0;
  bit          t6_active = 1'b0;

  localparam logic [511:0] ABC  = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] ONES = {512{1'b1}};

  sha256_w_stream #(.ROUNDS(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .block_in(block_in), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_w(out_w), .out_idx(out_idx), .out_last(out_last)
  );

  sha256_w_stream #(.ROUNDS(16), .IDX_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .block_in(block_in16), .abort(1'b0), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_w(out_w16), .out_idx(out_idx16),
    .out_last(out_last16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule written as the textbook 64-entry recurrence.
  task automatic build_ref(input logic [511:0] blk);
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) ref_w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      a = rr(ref_w[i-15], 7) ^ rr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
      b = rr(ref_w[i-2], 17) ^ rr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
      ref_w[i] = b + ref_w[i-7] + a + ref_w[i-16];
    end
  endtask

  task automatic load64(input logic [511:0] blk);
    int n = 0;
    exp_t e;
    build_ref(blk);
    for (int i = 0; i < 64; i++) begin
      e.w = ref_w[i]; e.idx = 6'(i); e.last = (i == 63);
      sb.push_back(e);
    end
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) fail_now("load_wait_in_ready");
    block_in = blk;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) fail_now("drain_timeout");
    sb.delete();
    check("in_ready_after_last", 64'(in_ready), 64'd1);
    check("out_valid_after_last", 64'(out_valid), 64'd0);
  endtask

  task automatic wait_idx(input int idx, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (out_valid && out_idx == 6'(idx)) ok = 1'b1;
    end
  endtask

  // Output-ready pattern generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_ctl)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor for the 64-round instance: compare accepted beats, check stall stability.
  initial begin : mon64
    exp_t        e;
    bit          stalled;
    logic [38:0] held;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("stall_stable", 64'({out_w, out_idx, out_last}), 64'(held));
        if (out_ready) begin
          stalled = 1'b0;
          beats64++;
          got_w[out_idx] = out_w;
          if (sb.size() == 0) begin
            fail_now("unexpected_beat64");
          end else begin
            e = sb.pop_front();
            check("w", 64'(out_w), 64'(e.w));
            check("idx", 64'(out_idx), 64'(e.idx));
            check("last", 64'(out_last), 64'(e.last));
          end
        end else begin
          stalled = 1'b1;
          held = {out_w, out_idx, out_last};
        end
      end
    end
  end

  // Monitor for the 16-round instance, including the gap between blocks.
  initial begin : mon16
    exp_t e;
    int   gap;
    bit   seen_last;
    gap = 0;
    seen_last = 1'b0;
    forever begin
      @(negedge clk);
      if (t6_active && !rst) begin
        if (!out_valid16) begin
          gap++;
          check("idle16_in_ready", 64'(in_ready16), 64'd1);
        end else if (out_ready16) begin
          beats16++;
          if (out_idx16 == 4'd0 && seen_last) check("gap16", 64'(gap), 64'd1);
          if (out_last16) begin seen_last = 1'b1; gap = 0; end
          if (sb16.size() == 0) begin
            fail_now("unexpected_beat16");
          end else begin
            e = sb16.pop_front();
            check("w16", 64'(out_w16), 64'(e.w));
            check("idx16", 64'({2'b00, out_idx16}), 64'(e.idx));
            check("last16", 64'(out_last16), 64'(e.last));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          ok;
    int          n;
    exp_t        e;
    logic [511:0] pat;

    // Reset state, no clock edge needed.
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_w", 64'(out_w), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst16_in_ready", 64'(in_ready16), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: "abc" block, sink always ready.
    ready_ctl = 0; beats64 = 0;
    load64(ABC);
    drain(200);
    check("t1_beats", 64'(beats64), 64'd64);
    check("abc_W0", 64'(got_w[0]), 64'h61626380);
    check("abc_W15", 64'(got_w[15]), 64'h00000018);
    check("abc_W16", 64'(got_w[16]), 64'h61626380);
    check("abc_W17", 64'(got_w[17]), 64'h000F0000);
    check("abc_W18", 64'(got_w[18]), 64'h7DA86405);

    // 2: same block, random backpressure.
    ready_ctl = 1; beats64 = 0;
    load64(ABC);
    drain(2000);
    ready_ctl = 0;
    check("t2_beats", 64'(beats64), 64'd64);
    check("t2_W18", 64'(got_w[18]), 64'h7DA86405);

    // 3: all-ones block.
    beats64 = 0;
    load64(ONES);
    drain(200);
    check("ones_W16", 64'(got_w[16]), 64'h203FFFFC);
    check("t3_beats", 64'(beats64), 64'd64);

    // abort in IDLE beats a simultaneous load request.
    abort = 1'b1; in_valid = 1'b1; block_in = ABC;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("idle_abort_in_ready", 64'(in_ready), 64'd1);
    check("idle_abort_out_valid", 64'(out_valid), 64'd0);

    // 4: abort during the idx=20 accept.
    load64(ABC);
    wait_idx(20, ok);
    if (!ok) fail_now("wait_idx20_timeout");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_idx", 64'(out_idx), 64'd0);
    check("abort_remaining", 64'(sb.size()), 64'd43);
    sb.delete();
    for (int i = 0; i < 16; i++) pat[511 - 32*i -: 32] = 32'h01234567 * 32'(i + 1) ^ 32'hA5A5_0000;
    beats64 = 0;
    load64(pat);
    drain(200);
    check("t4_beats", 64'(beats64), 64'd64);

    // 5: asynchronous reset between edges while idx=30 is presented.
    load64(ONES);
    wait_idx(30, ok);
    if (!ok) fail_now("wait_idx30_timeout");
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_idx", 64'(out_idx), 64'd0);
    check("rst_mid_remaining", 64'(sb.size()), 64'd33);
    #1 rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    beats64 = 0;
    load64(ABC);
    drain(200);
    check("t5_beats", 64'(beats64), 64'd64);

    // 6: ROUNDS=16 instance, back-to-back loads with in_valid held high.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) begin
        pat = ABC;
        e.w = pat[511 - 32*i -: 32]; e.idx = 6'(i); e.last = (i == 15);
        sb16.push_back(e);
      end
    end
    block_in16 = ABC;
    t6_active = 1'b1;
    beats16 = 0;
    in_valid16 = 1'b1;
    n = 0;
    while (sb16.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    in_valid16 = 1'b0;
    if (sb16.size() != 0) fail_now("t6_drain_timeout");
    repeat (3) @(posedge clk);
    #1;
    t6_active = 1'b0;
    check("t6_beats", 64'(beats16), 64'd48);
    check("t6_in_ready_end", 64'(in_ready16), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
